// File: rtl/gray_count_reader.sv
// Purpose : synchronize a Gray-coded count from another clock domain, decode it to
//           binary, flag illegal multi-bit steps and measure count rate per gate.
// Latency : gray_in -> count_bin SYNC_STAGES+1 cycles; freq_valid every GATE_CYCLES
//           cycles once a PRIME gate and a MEASURE gate have completed.
// Backpressure: none; freq_out/freq_valid is a one-cycle pulse that is not held off.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-high reset
//   en         - measurement enable; low forces IDLE, next high re-primes
//   err_clr    - one-cycle clear of step_err (a coincident new error wins)
//   gray_in    - Gray-coded count from an asynchronous counter domain
//   count_bin  - synchronized count decoded to binary
//   freq_out   - count increment over the last complete gate (modular)
//   freq_valid - one-cycle pulse marking a new freq_out
//   step_err   - sticky flag: consecutive synchronized samples differed in >1 bit
module gray_count_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int GATE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] count_bin,
  output logic [DATA_WIDTH-1:0] freq_out,
  output logic                  freq_valid,
  output logic                  step_err
);

  // Timer holds 0..GATE_CYCLES-1, so $clog2(GATE_CYCLES) bits always suffice.
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] TC_VAL = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] gray_prev;
  logic [DATA_WIDTH-1:0] bin_d;
  logic [DATA_WIDTH-1:0] gray_diff;
  logic                  multi_step;
  logic [DATA_WIDTH-1:0] prev;
  logic [TW-1:0]         timer;
  logic                  tc;
  state_t                state;

  // Synchronizer chain on the asynchronous Gray bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Binary bit i is the XOR of Gray bits DATA_WIDTH-1..i.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign gray_diff  = sync_q[SYNC_STAGES-1] ^ gray_prev;
  assign multi_step = |(gray_diff & (gray_diff - DATA_WIDTH'(1)));

  // Decode and step check run regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_bin <= '0;
      gray_prev <= '0;
      step_err  <= 1'b0;
    end else begin
      count_bin <= bin_d;
      gray_prev <= sync_q[SYNC_STAGES-1];
      if (multi_step) begin
        step_err <= 1'b1;
      end else if (err_clr) begin
        step_err <= 1'b0;
      end
    end
  end

  assign tc = (timer == TC_VAL);

  // Gate FSM. A TC in MEASURE is reported even if en drops on that same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      prev       <= '0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (en) state <= PRIME;
        end
        PRIME: begin
          if (!en) begin
            state <= IDLE;
            timer <= '0;
          end else if (tc) begin
            prev  <= count_bin;
            timer <= '0;
            state <= MEASURE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MEASURE: begin
          if (tc) begin
            freq_out   <= count_bin - prev;
            prev       <= count_bin;
            freq_valid <= 1'b1;
            timer      <= '0;
            if (!en) state <= IDLE;
          end else if (!en) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_count_reader.sv
// Purpose : directed self-checking bench for gray_count_reader (8-bit, 16-cycle gate).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_gray_count_reader;

  logic       clk;
  logic       rst;
  logic       en;
  logic       err_clr;
  logic [7:0] gray_in;
  logic [7:0] count_bin;
  logic [7:0] freq_out;
  logic       freq_valid;
  logic       step_err;

  int total = 0;
  int bad   = 0;

  // Binary source counter, advanced once every two clocks when src_run is set.
  logic       src_run = 1'b0;
  logic       src_ph  = 1'b0;
  logic [7:0] src     = 8'h00;

  gray_count_reader #(
    .DATA_WIDTH (8),
    .GATE_CYCLES(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .err_clr   (err_clr),
    .gray_in   (gray_in),
    .count_bin (count_bin),
    .freq_out  (freq_out),
    .freq_valid(freq_valid),
    .step_err  (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (src_run) begin
      src_ph = ~src_ph;
      if (!src_ph) src = src + 8'd1;
      gray_in = src ^ (src >> 1);
    end
  endtask

  // Ticks until freq_valid is seen (bounded) and checks how many ticks it took.
  task automatic wait_valid(input string name, input int exp_n);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (n < 100 && !found) begin
      tick();
      n++;
      if (freq_valid) found = 1'b1;
    end
    check(name, found ? n : -1, exp_n);
  endtask

  typedef struct {
    logic [7:0] gray;
    logic       clr;
    logic [7:0] exp_cnt;
    logic       exp_err;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int nv;

    // Row k: inputs applied before edge k, outputs expected just after it.
    vecs[0]  = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{8'h01, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{8'h01, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{8'h01, 1'b0, 8'h01, 1'b0}; // count_bin 3 cycles after change
    vecs[4]  = '{8'h01, 1'b0, 8'h01, 1'b0};
    vecs[5]  = '{8'h00, 1'b0, 8'h01, 1'b0}; // legal single-bit step back
    vecs[6]  = '{8'h00, 1'b0, 8'h01, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{8'h03, 1'b0, 8'h00, 1'b0}; // illegal 0x00->0x03
    vecs[9]  = '{8'h03, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{8'h03, 1'b0, 8'h02, 1'b1}; // step_err three cycles later
    vecs[11] = '{8'h03, 1'b1, 8'h02, 1'b0}; // err_clr clears
    vecs[12] = '{8'h00, 1'b0, 8'h02, 1'b0}; // illegal 0x03->0x00
    vecs[13] = '{8'h00, 1'b0, 8'h02, 1'b0};
    vecs[14] = '{8'h00, 1'b1, 8'h00, 1'b1}; // set coincident with clear: set wins
    vecs[15] = '{8'h00, 1'b0, 8'h00, 1'b1}; // sticky
    vecs[16] = '{8'h00, 1'b1, 8'h00, 1'b0};

    rst = 1'b1;
    en = 1'b0;
    err_clr = 1'b0;
    gray_in = 8'h00;
    #12;
    check("reset count_bin", {24'd0, count_bin}, 0);
    check("reset freq_out", {24'd0, freq_out}, 0);
    check("reset freq_valid", {31'd0, freq_valid}, 0);
    check("reset step_err", {31'd0, step_err}, 0);
    tick();
    rst = 1'b0;

    // Latency and step-error table, en held low.
    nv = 17;
    for (int i = 0; i < nv; i++) begin
      gray_in = vecs[i].gray;
      err_clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d count_bin", i), {24'd0, count_bin}, {24'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d step_err", i), {31'd0, step_err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d freq_valid", i), {31'd0, freq_valid}, 0);
    end
    err_clr = 1'b0;

    // Rate: clean start, source from 0, en sampled on the first edge.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    src = 8'h00;
    src_ph = 1'b0;
    gray_in = 8'h00;
    src_run = 1'b1;
    en = 1'b1;
    tick();
    wait_valid("rate first valid", 32);
    check("rate freq_out 1", {24'd0, freq_out}, 8);
    tick();
    check("rate valid pulse width", {31'd0, freq_valid}, 0);
    wait_valid("rate period", 15);
    check("rate freq_out 2", {24'd0, freq_out}, 8);
    check("rate step_err", {31'd0, step_err}, 0);

    // en falls on the MEASURE TC cycle: result still delivered.
    for (int i = 0; i < 15; i++) tick();
    en = 1'b0;
    tick();
    check("en-at-tc valid", {31'd0, freq_valid}, 1);
    check("en-at-tc freq_out", {24'd0, freq_out}, 8);
    tick();
    check("en-at-tc then idle", {31'd0, freq_valid}, 0);

    // Re-prime, then drop en at timer=7 of MEASURE.
    en = 1'b1;
    tick();
    wait_valid("reprime valid", 32);
    for (int i = 0; i < 7; i++) tick();
    en = 1'b0;
    begin
      int vcnt;
      vcnt = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (freq_valid) vcnt++;
      end
      check("en low no valid", vcnt, 0);
    end
    check("en low freq_out hold", {24'd0, freq_out}, 8);
    en = 1'b1;
    tick();
    wait_valid("en reassert valid", 32);
    check("en reassert freq_out", {24'd0, freq_out}, 8);

    // Mid-run asynchronous reset: outputs clear without waiting for an edge.
    tick();
    check("pre-reset count_bin nonzero", {31'd0, (count_bin != 8'h00)}, 1);
    rst = 1'b1;
    src_run = 1'b0;
    src = 8'h00;
    gray_in = 8'h00;
    #1;
    check("midrst count_bin", {24'd0, count_bin}, 0);
    check("midrst freq_out", {24'd0, freq_out}, 0);
    check("midrst freq_valid", {31'd0, freq_valid}, 0);
    check("midrst step_err", {31'd0, step_err}, 0);
    tick();
    tick();
    rst = 1'b0;
    src_ph = 1'b0;
    src_run = 1'b1;
    tick();
    wait_valid("post-reset valid", 32);
    check("post-reset freq_out", {24'd0, freq_out}, 8);

    // Wrap: source parked at 0xF4, clear the jump-induced error, then run so
    // the MEASURE gate spans roughly 0xFC -> 0x04.
    en = 1'b0;
    src_run = 1'b0;
    src = 8'hF4;
    gray_in = src ^ (src >> 1);
    for (int i = 0; i < 6; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wrap pre step_err", {31'd0, step_err}, 0);
    src_ph = 1'b0;
    src_run = 1'b1;
    en = 1'b1;
    tick();
    wait_valid("wrap valid", 32);
    check("wrap freq_out", {24'd0, freq_out}, 8);
    check("wrap step_err", {31'd0, step_err}, 0);
    wait_valid("wrap period", 16);
    check("wrap freq_out 2", {24'd0, freq_out}, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
